// File: rtl/corr_pkg.sv
// Shared types and constants for the windowed correlation counter.
package corr_pkg;

    localparam int TIME_W_DEF = 8;

    typedef logic [TIME_W_DEF-1:0] count_t;

    localparam count_t COUNT_MAX = '1;

    typedef struct packed {
        count_t X;
        count_t Y;
        count_t Isect;
        count_t Symdiff;
    } corr_result_t;

    // Slot of each statistic in the counter bank
    localparam int IDX_X       = 0;
    localparam int IDX_Y       = 1;
    localparam int IDX_ISECT   = 2;
    localparam int IDX_SYMDIFF = 3;
    localparam int N_CNT       = 4;

endpackage

// File: rtl/corr_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module corr_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/corr_count_window.sv
// Windowed X/Y/AND/XOR counter over two selectable probe bits, with a
// snapshot result register read out through a valid/ready handshake.
module corr_count_window
    import corr_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int TIME_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cg,
    input  logic [N_CH-1:0]   i_bits,
    input  logic [SEL_W-1:0]  i_xSel,
    input  logic [SEL_W-1:0]  i_ySel,
    input  logic [TIME_W-1:0] i_windowLenM1,
    input  logic              i_restart,
    output logic [TIME_W-1:0] o_t,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [TIME_W-1:0] o_countX,
    output logic [TIME_W-1:0] o_countY,
    output logic [TIME_W-1:0] o_countIsect,
    output logic [TIME_W-1:0] o_countSymdiff,
    output logic              o_overrun
);

    logic              armed_reg;
    logic [SEL_W-1:0]  xsel_reg;
    logic [SEL_W-1:0]  ysel_reg;
    logic [TIME_W-1:0] lenm1_reg;
    logic [TIME_W-1:0] t_reg;
    logic              valid_reg;
    logic              overrun_reg;

    logic [SEL_W-1:0]  xsel_in;
    logic [SEL_W-1:0]  ysel_in;
    logic              x_bit;
    logic              y_bit;
    logic              complete;
    logic              clear;
    logic              transfer;
    logic [N_CNT-1:0]  inc;

    // Out-of-range selects fall back to channel 0
    assign xsel_in = (int'(i_xSel) < N_CH) ? i_xSel : '0;
    assign ysel_in = (int'(i_ySel) < N_CH) ? i_ySel : '0;

    assign x_bit = i_bits[xsel_reg];
    assign y_bit = i_bits[ysel_reg];

    assign inc[IDX_X]       = i_cg & x_bit;
    assign inc[IDX_Y]       = i_cg & y_bit;
    assign inc[IDX_ISECT]   = i_cg & x_bit & y_bit;
    assign inc[IDX_SYMDIFF] = i_cg & (x_bit ^ y_bit);

    // Restart outranks completion; the first edge after reset acts as a restart
    assign complete = armed_reg && !i_restart && i_cg && (t_reg == lenm1_reg);
    assign clear    = !armed_reg || i_restart || complete;
    assign transfer = valid_reg && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_reg <= 1'b0;
            xsel_reg  <= '0;
            ysel_reg  <= '0;
            lenm1_reg <= '0;
            t_reg     <= '0;
        end else begin
            armed_reg <= 1'b1;
            if (clear) begin
                xsel_reg  <= xsel_in;
                ysel_reg  <= ysel_in;
                lenm1_reg <= i_windowLenM1;
                t_reg     <= '0;
            end else if (i_cg) begin
                t_reg <= t_reg + TIME_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [TIME_W-1:0] live;
            logic [TIME_W-1:0] final_cnt;
            logic [TIME_W-1:0] res_reg;

            corr_sat_counter #(.W(TIME_W)) u_cnt (
                .clk   (i_clk),
                .rst_n (i_rst_n),
                .clr   (clear),
                .inc   (inc[gi]),
                .value (live)
            );

            // Snapshot must include the sample taken on the completing edge
            assign final_cnt = (live == '1) ? live : live + TIME_W'(inc[gi]);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    res_reg <= '0;
                end else if (complete) begin
                    res_reg <= final_cnt;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (complete) begin
            valid_reg   <= 1'b1;
            overrun_reg <= valid_reg && !i_ready;
        end else if (transfer) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end
    end

    assign o_t            = t_reg;
    assign o_valid        = valid_reg;
    assign o_overrun      = overrun_reg;
    assign o_countX       = g_cnt[IDX_X].res_reg;
    assign o_countY       = g_cnt[IDX_Y].res_reg;
    assign o_countIsect   = g_cnt[IDX_ISECT].res_reg;
    assign o_countSymdiff = g_cnt[IDX_SYMDIFF].res_reg;

endmodule

// File: tb/tb_corr_count_window.sv
// Bench for corr_count_window: directed table, corner sequences, and random run
// against a window-level reference model.
module tb_corr_count_window;
    import corr_pkg::*;

    localparam int N_CH = 8;
    localparam int TW   = 8;
    localparam int SW   = 3;
    localparam int CMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cg = 1'b0;
    logic [N_CH-1:0] bits = '0;
    logic [SW-1:0] xsel = '0;
    logic [SW-1:0] ysel = 3'd1;
    logic [TW-1:0] lenm1 = 8'd3;
    logic          restart = 1'b0;
    logic          ready = 1'b0;
    logic [TW-1:0] o_t;
    logic          o_valid;
    logic [TW-1:0] o_cx, o_cy, o_ci, o_cs;
    logic          o_overrun;

    corr_count_window #(.N_CH(N_CH), .TIME_W(TW), .SEL_W(SW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cg           (cg),
        .i_bits         (bits),
        .i_xSel         (xsel),
        .i_ySel         (ysel),
        .i_windowLenM1  (lenm1),
        .i_restart      (restart),
        .o_t            (o_t),
        .o_valid        (o_valid),
        .i_ready        (ready),
        .o_countX       (o_cx),
        .o_countY       (o_cy),
        .o_countIsect   (o_ci),
        .o_countSymdiff (o_cs),
        .o_overrun      (o_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the current window is kept as the list of samples taken so far
    bit           m_armed;
    int           m_xs, m_ys, m_len;
    int           qx[$];
    int           qy[$];
    bit           m_valid, m_ovr;
    corr_result_t m_res;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void model_reset();
        m_armed = 0; m_valid = 0; m_ovr = 0; m_res = '0;
        qx.delete(); qy.delete();
        m_xs = 0; m_ys = 0; m_len = 0;
    endfunction

    function automatic void model_load();
        m_xs  = (int'(xsel) < N_CH) ? int'(xsel) : 0;
        m_ys  = (int'(ysel) < N_CH) ? int'(ysel) : 0;
        m_len = int'(lenm1);
        qx.delete(); qy.delete();
    endfunction

    function automatic void model_step();
        bit xfer = m_valid && ready;
        bit done = 0;
        int sx = 0, sy = 0, si = 0, sd = 0;
        if (!m_armed || restart) begin
            m_armed = 1;
            model_load();
        end else if (cg) begin
            qx.push_back(int'(bits[m_xs]));
            qy.push_back(int'(bits[m_ys]));
            if (qx.size() == m_len + 1) begin
                done = 1;
                foreach (qx[i]) begin
                    sx += qx[i]; sy += qy[i];
                    si += qx[i] & qy[i]; sd += qx[i] ^ qy[i];
                end
                m_res.X       = TW'(sat(sx));
                m_res.Y       = TW'(sat(sy));
                m_res.Isect   = TW'(sat(si));
                m_res.Symdiff = TW'(sat(sd));
                m_ovr   = m_valid && !xfer;
                m_valid = 1;
                model_load();
            end
        end
        if (!done && xfer) begin
            m_valid = 0;
            m_ovr   = 0;
        end
    endfunction

    task automatic compare_model();
        chk("model_t", o_t, qx.size());
        chk("model_valid", o_valid, m_valid);
        chk("model_overrun", o_overrun, m_ovr);
        chk("model_cnt_x", o_cx, m_res.X);
        chk("model_cnt_y", o_cy, m_res.Y);
        chk("model_cnt_isect", o_ci, m_res.Isect);
        chk("model_cnt_symdiff", o_cs, m_res.Symdiff);
    endtask

    // Inputs are already applied; advance one edge and sample 1 time unit later
    task automatic step(input bit cmp_model);
        model_step();
        @(posedge clk);
        #1;
        if (cmp_model) compare_model();
    endtask

    task automatic sample2(input bit b0, input bit b1, input bit rdy);
        cg = 1'b1; bits = '0; bits[0] = b0; bits[1] = b1; ready = rdy;
        step(1'b1);
    endtask

    task automatic check_res(input string name, input int v, input int ov,
                             input int x, input int y, input int i, input int s);
        chk({name, "_valid"}, o_valid, v);
        chk({name, "_overrun"}, o_overrun, ov);
        chk({name, "_x"}, o_cx, x);
        chk({name, "_y"}, o_cy, y);
        chk({name, "_isect"}, o_ci, i);
        chk({name, "_symdiff"}, o_cs, s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_t", o_t, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_counts", {o_cx, o_cy, o_ci, o_cs}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit cg; bit b0; bit b1; bit rdy;
        int t;  bit v;  int cx; int cy; int ci; int cs;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Basic window then the same stimulus with alternate gated cycles
        tbl[0]  = '{1,1,1,0, 1,0, 0,0,0,0};
        tbl[1]  = '{1,1,0,0, 2,0, 0,0,0,0};
        tbl[2]  = '{1,0,0,0, 3,0, 0,0,0,0};
        tbl[3]  = '{1,1,1,0, 0,1, 3,2,2,1};
        tbl[4]  = '{0,0,0,1, 0,0, 3,2,2,1};
        tbl[5]  = '{0,1,1,0, 0,0, 3,2,2,1};
        tbl[6]  = '{1,1,1,0, 1,0, 3,2,2,1};
        tbl[7]  = '{0,0,1,0, 1,0, 3,2,2,1};
        tbl[8]  = '{1,1,0,0, 2,0, 3,2,2,1};
        tbl[9]  = '{0,1,1,0, 2,0, 3,2,2,1};
        tbl[10] = '{1,0,0,0, 3,0, 3,2,2,1};
        tbl[11] = '{0,1,0,0, 3,0, 3,2,2,1};
        tbl[12] = '{1,1,1,0, 0,1, 3,2,2,1};
        tbl[13] = '{0,0,0,1, 0,0, 3,2,2,1};

        model_reset();
        @(posedge clk); #1;
        do_reset();
        xsel = 3'd0; ysel = 3'd1; lenm1 = 8'd3; cg = 1'b0;
        step(1'b1);

        for (int r = 0; r < 14; r++) begin
            cg = tbl[r].cg; bits = '0; bits[0] = tbl[r].b0; bits[1] = tbl[r].b1;
            ready = tbl[r].rdy;
            step(1'b0);
            chk($sformatf("tbl%0d_t", r), o_t, tbl[r].t);
            check_res($sformatf("tbl%0d", r), tbl[r].v, 0,
                      tbl[r].cx, tbl[r].cy, tbl[r].ci, tbl[r].cs);
        end

        // Overrun: two windows of length 2 with nobody reading
        lenm1 = 8'd1; restart = 1'b1; cg = 1'b1; ready = 1'b0;
        step(1'b1);
        restart = 1'b0;
        sample2(1, 0, 0); sample2(1, 0, 0);
        sample2(1, 1, 0); sample2(0, 1, 0);
        check_res("ovr", 1, 1, 1, 2, 1, 1);
        cg = 1'b0; ready = 1'b1;
        step(1'b1);
        chk("ovr_clear_valid", o_valid, 0);
        chk("ovr_clear_overrun", o_overrun, 0);

        // Transfer on the completing edge of a later window clears overrun
        sample2(1, 1, 0); sample2(1, 1, 0);
        sample2(0, 0, 0); sample2(0, 0, 0);
        chk("coin_pre_overrun", o_overrun, 1);
        sample2(1, 0, 0); sample2(0, 1, 1);
        check_res("coin", 1, 0, 1, 1, 0, 2);

        // Saturation over a 256-sample window
        xsel = 3'd2; ysel = 3'd5; lenm1 = 8'd255; bits = '1;
        restart = 1'b1; cg = 1'b1; ready = 1'b1;
        step(1'b1);
        restart = 1'b0;
        for (int i = 0; i < 256; i++) step(1'b1);
        check_res("sat", 1, 0, 255, 255, 255, 0);

        // Restart at t=2 retargets X to bit 3 and leaves the pending result alone
        ready = 1'b0; xsel = 3'd0; ysel = 3'd1; lenm1 = 8'd7; restart = 1'b1; bits = 8'h01;
        step(1'b1);
        restart = 1'b0;
        step(1'b1); step(1'b1);
        chk("rs_pre_t", o_t, 2);
        xsel = 3'd3; lenm1 = 8'd3; bits = 8'h08; restart = 1'b1;
        step(1'b1);
        restart = 1'b0;
        chk("rs_t", o_t, 0);
        check_res("rs_hold", 1, 0, 255, 255, 255, 0);
        for (int i = 0; i < 4; i++) step(1'b1);
        check_res("rs_bit3", 1, 1, 4, 0, 0, 4);

        // Reset mid-window
        bits = 8'h0F; step(1'b1); step(1'b1);
        do_reset();
        cg = 1'b0; ready = 1'b0;
        step(1'b1);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            cg      = ($urandom_range(0, 3) != 0);
            bits    = N_CH'($urandom);
            ready   = ($urandom_range(0, 2) == 0);
            restart = cg && ($urandom_range(0, 40) == 0);
            xsel    = SW'($urandom);
            ysel    = SW'($urandom);
            lenm1   = TW'($urandom_range(0, 5));
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step(1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/corr_count_window.md
# corr_count_window

Windowed multi-channel correlation counter with result snapshot and valid/ready readout. Each window of `i_windowLenM1+1` sampled cycles counts X, Y, X AND Y, and X XOR Y over two channels selected from an `N_CH`-bit input vector. At window end the totals are latched into a holding register for the host-side reader, and counting restarts with no gap. It sits between the probe sampler and the bridge register file in the correlator datapath, and replaces the free-running rectangular counter that needed external window control.

## Interface
- `N_CH`, default 8: number of probe input bits; must be ≥2.
- `TIME_W`, default 8: width of window-length, time and count values.
- `SEL_W`, default `$clog2(N_CH)`: channel-select width.
- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, asynchronous assert, active-low; synchronous deassert is the caller's responsibility.
- `i_cg` input 1: sample enable; only cycles with `i_cg=1` are counted and advance `o_t`.
- `i_bits` input `N_CH`: probe samples.
- `i_xSel` input `SEL_W`: X channel index, captured at window start.
- `i_ySel` input `SEL_W`: Y channel index, captured at window start.
- `i_windowLenM1` input `TIME_W`: window length minus one, captured at window start.
- `i_restart` input 1: abort the current window and begin a new one.
- `o_t` output `TIME_W`: sample index within the current window.
- `o_valid` output 1: result registers hold an unread window.
- `i_ready` input 1: reader accepts the result when `o_valid=1`.
- `o_countX`, `o_countY`, `o_countIsect`, `o_countSymdiff` output `TIME_W` each: latched window totals.
- `o_overrun` output 1: the presented result overwrote an unread one.

## Operation
- Config registers `xSel`, `ySel` and `lenM1` load from the inputs at reset release (first edge after `i_rst_n` rises), on `i_restart`, and on window completion. A select value ≥`N_CH` reads as channel 0.
- On a sample cycle (`i_cg=1`): x=`i_bits[xSel]`, y=`i_bits[ySel]`. Four live counters increment by x, y, x&y and x^y respectively.
- Counters saturate at all-ones, which is reachable only when `lenM1` is all-ones.
- Window completion is a sample cycle with `t==lenM1`. On that edge:
  - result registers load the live counts including the final sample;
  - live counters and `t` go to 0;
  - config is recaptured.
- `i_restart` zeroes the live counters and `t` and recaptures config. It produces no result. It has priority over completion in the same cycle. It does not affect `o_valid`, the result registers or `o_overrun`.
- Readout is a valid/ready transfer: a transfer happens when `o_valid & i_ready`. `o_valid` sets on completion and clears on a transfer with no simultaneous completion.
- Completion while `o_valid=1` and no transfer in that cycle: the new result overwrites the old one, `o_valid` stays 1 and `o_overrun` sets.
- Completion in the same cycle as a transfer: the new result loads, `o_valid` stays 1 and `o_overrun` is 0.
- `o_overrun` clears on any transfer that has no simultaneous overwrite.
- With `i_cg=0`, all state holds except the readout handshake.

## Timing
- All outputs are registered.
- Reset values: `o_t`=0, all counts 0, `o_valid`=0, `o_overrun`=0; live counters 0.
- Completion latency: the result is visible and `o_valid`=1 one cycle after the final sample edge.
- There is no dead cycle between windows. The sample on the cycle after completion is sample 0 of the next window.
- `lenM1`=0: every sample cycle completes a window. Each count is then 0 or 1.
- Reset asserted mid-window or mid-handshake clears everything immediately. The partial window is discarded.

## Structure
- Shared package `corr_pkg` holds:
  - the `count_t` typedef, a `TIME_W`-wide vector;
  - a `COUNT_MAX` constant;
  - a `corr_result_t` struct with fields X, Y, Isect, Symdiff.
- One sub-module, `corr_sat_counter`:
  - ports: clock, active-low async reset, synchronous clear, increment and value;
  - saturates at all-ones;
  - instantiated four times.
- Window/time control, config capture and the result/handshake register stay in the top module.

## Test plan
- Basic window: `TIME_W`=8, `lenM1`=3, `i_cg`=1, xSel=0, ySel=1, bit0 pattern 1,1,0,1 and bit1 pattern 1,0,0,1 → one cycle after the 4th sample: X=3, Y=2, Isect=2, Symdiff=1, `o_valid`=1, `o_t`=0.
- Gated sampling: same stimulus with `i_cg` low on alternate cycles → identical result; completion occurs 8 cycles after start instead of 4.
- Overrun: `lenM1`=1, `i_ready`=0 for two windows → `o_valid`=1, second window's counts presented, `o_overrun`=1. Then `i_ready`=1 for one cycle → `o_valid`=0, `o_overrun`=0.
- Transfer coincident with completion: `i_ready` pulsed on the completion cycle of window 2 → window-2 result presented, `o_valid`=1, `o_overrun`=0.
- Saturation: `lenM1`=255, both selected bits constantly 1 → X=Y=Isect=255, Symdiff=0.
- Restart and reset: `i_restart` at `t`=2 with new xSel=3 → `o_t`=0, no result, subsequent counts use bit3. `i_rst_n` low mid-window → all outputs 0 asynchronously.
